// File: rtl/uop_issue_queue.sv
// uop_issue_queue
//
// Purpose:
//   Circular buffer between the uop translator and the RF stage. It accepts
//   one 39-bit uop per cycle from the translator and presents the oldest
//   buffered uop on Iword. While the RF stage stalls, the head uop stays on
//   Iword. When the queue is empty, or while RST is low, NOP_UOP is driven.
//   An EXE-stage PC redirect (PCupdate) discards every buffered uop.
//
// Ports:
//   CLK          in   clock; all state changes on the rising edge
//   RST          in   synchronous active-low reset
//   uop_in       in   39-bit uop from translator ([27] = EOI)
//   uop_valid    in   uop_in is valid this cycle
//   uop_ready    out  queue accepts uop_in this cycle (registered state + RST)
//   Iword        out  uop presented to the RF stage (NOP_UOP when empty)
//   issue_valid  out  Iword carries a real queued uop
//   pipe_stall   in   RF stage cannot consume Iword this cycle
//   PCupdate     in   EXE redirect; flush the queue at the edge
//   occupancy    out  number of valid entries (0..DEPTH)
//   eoi_pending  out  number of valid entries with the EOI bit set
module uop_issue_queue #(
  parameter int          DEPTH   = 4,
  parameter int          PTR_W   = 2,
  parameter logic [38:0] NOP_UOP = 39'h0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [38:0]      uop_in,
  input  logic             uop_valid,
  output logic             uop_ready,
  output logic [38:0]      Iword,
  output logic             issue_valid,
  input  logic             pipe_stall,
  input  logic             PCupdate,
  output logic [PTR_W:0]   occupancy,
  output logic [PTR_W:0]   eoi_pending
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);

  logic [38:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_occ;
  logic [PTR_W:0]   r_eoi;

  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_pushEoi;
  logic w_popEoi;

  // Ready depends only on registered occupancy and RST, so a full queue that
  // pops this cycle still refuses the incoming uop; it is taken next cycle.
  assign w_empty   = (r_occ == '0);
  assign uop_ready = RST & (r_occ != FULL_CNT);

  // A redirect suppresses both push and pop in its own cycle.
  assign w_push    = uop_valid & uop_ready & ~PCupdate;
  assign w_pop     = ~pipe_stall & ~w_empty & ~PCupdate;
  assign w_pushEoi = w_push & uop_in[27];
  assign w_popEoi  = w_pop & r_mem[r_head][27];

  // Issue side is purely a function of registered state and RST; there is
  // no bypass from uop_in, so a push becomes visible the following cycle.
  assign Iword       = (w_empty || !RST) ? NOP_UOP : r_mem[r_head];
  assign issue_valid = ~w_empty & RST;

  assign occupancy   = r_occ;
  assign eoi_pending = r_eoi;

  // Storage has no reset: entries are only ever read while counted valid.
  always_ff @(posedge CLK) begin
    if (RST && w_push) begin
      r_mem[r_tail] <= uop_in;
    end
  end

  // Pointer, occupancy and EOI bookkeeping. Reset takes priority over the
  // flush, and the flush over any push/pop. Simultaneous push and pop leave
  // occupancy unchanged; EOI count applies the net of both edges.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_eoi  <= '0;
    end else if (PCupdate) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_eoi  <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + ONE_PTR;
      end
      if (w_pop) begin
        r_head <= r_head + ONE_PTR;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + ONE_CNT;
        2'b01:   r_occ <= r_occ - ONE_CNT;
        default: r_occ <= r_occ;
      endcase
      case ({w_pushEoi, w_popEoi})
        2'b10:   r_eoi <= r_eoi + ONE_CNT;
        2'b01:   r_eoi <= r_eoi - ONE_CNT;
        default: r_eoi <= r_eoi;
      endcase
    end
  end

endmodule

// File: tb/tb_uop_issue_queue.sv
// tb_uop_issue_queue
//
// Purpose:
//   Directed bench for uop_issue_queue (DEPTH=4). A table of per-cycle
//   records gives the inputs for one cycle and the outputs expected during
//   that cycle (before the rising edge). A hand-written sequence then covers
//   a held uop_valid waiting through a full queue.
//
// Ports: none (top-level bench).
module tb_uop_issue_queue;

  logic        CLK;
  logic        RST;
  logic [38:0] uop_in;
  logic        uop_valid;
  logic        uop_ready;
  logic [38:0] Iword;
  logic        issue_valid;
  logic        pipe_stall;
  logic        PCupdate;
  logic [2:0]  occupancy;
  logic [2:0]  eoi_pending;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic        rst;
    logic [38:0] uopIn;
    logic        valid;
    logic        stall;
    logic        pc;
    logic [38:0] expIword;
    logic        expIv;
    logic        expRdy;
    logic [2:0]  expOcc;
    logic [2:0]  expEoi;
  } vecT;

  vecT vecs[$];

  uop_issue_queue #(
    .DEPTH  (4),
    .PTR_W  (2),
    .NOP_UOP(39'h0)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .uop_in     (uop_in),
    .uop_valid  (uop_valid),
    .uop_ready  (uop_ready),
    .Iword      (Iword),
    .issue_valid(issue_valid),
    .pipe_stall (pipe_stall),
    .PCupdate   (PCupdate),
    .occupancy  (occupancy),
    .eoi_pending(eoi_pending)
  );

  // Free-running 10-time-unit clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic addVec(input logic rst, input logic [38:0] uopIn,
                        input logic valid, input logic stall, input logic pc,
                        input logic [38:0] expIword, input logic expIv,
                        input logic expRdy, input logic [2:0] expOcc,
                        input logic [2:0] expEoi);
    vecT v;
    v.rst = rst;       v.uopIn = uopIn;   v.valid = valid;
    v.stall = stall;   v.pc = pc;         v.expIword = expIword;
    v.expIv = expIv;   v.expRdy = expRdy; v.expOcc = expOcc;
    v.expEoi = expEoi;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [38:0] actual,
                             input logic [38:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then sample the
  // outputs 1 unit later, well away from the next rising edge.
  task automatic applyStimulus(input logic rst, input logic [38:0] uopIn,
                               input logic valid, input logic stall,
                               input logic pc);
    @(negedge CLK);
    RST        = rst;
    uop_in     = uopIn;
    uop_valid  = valid;
    pipe_stall = stall;
    PCupdate   = pc;
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [38:0] expIword,
                          input logic expIv, input logic expRdy,
                          input logic [2:0] expOcc, input logic [2:0] expEoi);
    checkOutput({tag, ".Iword"}, Iword, expIword);
    checkOutput({tag, ".issue_valid"}, {38'h0, issue_valid}, {38'h0, expIv});
    checkOutput({tag, ".uop_ready"}, {38'h0, uop_ready}, {38'h0, expRdy});
    checkOutput({tag, ".occupancy"}, {36'h0, occupancy}, {36'h0, expOcc});
    checkOutput({tag, ".eoi_pending"}, {36'h0, eoi_pending}, {36'h0, expEoi});
  endtask

  // Main sequence: build the table, run it, then the held-valid sequence.
  initial begin
    RST = 1'b0; uop_in = '0; uop_valid = 1'b0; pipe_stall = 1'b0;
    PCupdate = 1'b0;

    //      rst uop_in        v  st pc  Iword         iv rdy occ eoi
    // Reset
    addVec(0, 39'h0,        0, 0, 0,  39'h0,        0, 0, 0, 0);
    addVec(0, 39'h0,        0, 0, 0,  39'h0,        0, 0, 0, 0);
    // A, B, C back to back, no stall
    addVec(1, 39'h1,        1, 0, 0,  39'h0,        0, 1, 0, 0);
    addVec(1, 39'h2,        1, 0, 0,  39'h1,        1, 1, 1, 0);
    addVec(1, 39'h8000002,  1, 0, 0,  39'h2,        1, 1, 1, 0);
    addVec(1, 39'h0,        0, 0, 0,  39'h8000002,  1, 1, 1, 1);
    addVec(1, 39'h0,        0, 0, 0,  39'h0,        0, 1, 0, 0);
    // Stalled fill of 5 (pointers start at 3 so they wrap)
    addVec(1, 39'h11,       1, 1, 0,  39'h0,        0, 1, 0, 0);
    addVec(1, 39'h12,       1, 1, 0,  39'h11,       1, 1, 1, 0);
    addVec(1, 39'h13,       1, 1, 0,  39'h11,       1, 1, 2, 0);
    addVec(1, 39'h14,       1, 1, 0,  39'h11,       1, 1, 3, 0);
    addVec(1, 39'h15,       1, 1, 0,  39'h11,       1, 0, 4, 0);
    // Full: pop with held push -> push blocked, 4 -> 3
    addVec(1, 39'h15,       1, 0, 0,  39'h11,       1, 0, 4, 0);
    // Push accepted with pop, 3 -> 3
    addVec(1, 39'h15,       1, 0, 0,  39'h12,       1, 1, 3, 0);
    addVec(1, 39'h0,        0, 0, 0,  39'h13,       1, 1, 3, 0);
    addVec(1, 39'h0,        0, 0, 0,  39'h14,       1, 1, 2, 0);
    addVec(1, 39'h0,        0, 0, 0,  39'h15,       1, 1, 1, 0);
    addVec(1, 39'h0,        0, 0, 0,  39'h0,        0, 1, 0, 0);
    // Occupancy 3 with 2 EOIs, then flush with a uop offered
    addVec(1, 39'h8000031,  1, 1, 0,  39'h0,        0, 1, 0, 0);
    addVec(1, 39'h32,       1, 1, 0,  39'h8000031,  1, 1, 1, 1);
    addVec(1, 39'h8000033,  1, 1, 0,  39'h8000031,  1, 1, 2, 1);
    addVec(1, 39'h34,       1, 0, 1,  39'h8000031,  1, 1, 3, 2);
    addVec(1, 39'h35,       1, 0, 0,  39'h0,        0, 1, 0, 0);
    addVec(1, 39'h0,        0, 0, 0,  39'h35,       1, 1, 1, 0);
    addVec(1, 39'h0,        0, 0, 0,  39'h0,        0, 1, 0, 0);
    // Occupancy 2, then mid-stream reset with push and pop requested
    addVec(1, 39'h8000041,  1, 1, 0,  39'h0,        0, 1, 0, 0);
    addVec(1, 39'h42,       1, 1, 0,  39'h8000041,  1, 1, 1, 1);
    addVec(0, 39'h43,       1, 0, 0,  39'h0,        0, 0, 2, 1);
    addVec(1, 39'h3,        1, 0, 0,  39'h0,        0, 1, 0, 0);
    addVec(1, 39'h0,        0, 0, 0,  39'h3,        1, 1, 1, 0);
    addVec(1, 39'h0,        0, 0, 0,  39'h0,        0, 1, 0, 0);
    // Empty queue, stall toggling and a flush while empty
    addVec(1, 39'h0,        0, 1, 0,  39'h0,        0, 1, 0, 0);
    addVec(1, 39'h0,        0, 0, 0,  39'h0,        0, 1, 0, 0);
    addVec(1, 39'h0,        0, 1, 0,  39'h0,        0, 1, 0, 0);
    addVec(1, 39'h0,        0, 0, 1,  39'h0,        0, 1, 0, 0);
    addVec(1, 39'h0,        0, 1, 0,  39'h0,        0, 1, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].uopIn, vecs[i].valid,
                    vecs[i].stall, vecs[i].pc);
      checkAll($sformatf("vec%0d", i), vecs[i].expIword, vecs[i].expIv,
               vecs[i].expRdy, vecs[i].expOcc, vecs[i].expEoi);
    end

    // Held uop_valid across a full queue: fill 4 EOI-mixed entries under
    // stall, keep offering 0x77, then release and drain in order.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 39'h8000071 + 39'(i), 1, 1, 0);
      checkAll($sformatf("fill%0d", i), (i == 0) ? 39'h0 : 39'h8000071,
               (i != 0), 1, 3'(i), 3'(i));
    end
    applyStimulus(1, 39'h77, 1, 1, 0);
    checkAll("hold0", 39'h8000071, 1, 0, 4, 4);
    applyStimulus(1, 39'h77, 1, 1, 0);
    checkAll("hold1", 39'h8000071, 1, 0, 4, 4);
    applyStimulus(1, 39'h77, 1, 0, 0);
    checkAll("rel0", 39'h8000071, 1, 0, 4, 4);
    applyStimulus(1, 39'h77, 1, 0, 0);
    checkAll("rel1", 39'h8000072, 1, 1, 3, 3);
    applyStimulus(1, 39'h0, 0, 0, 0);
    checkAll("drain0", 39'h8000073, 1, 1, 3, 2);
    applyStimulus(1, 39'h0, 0, 0, 0);
    checkAll("drain1", 39'h8000074, 1, 1, 2, 1);
    applyStimulus(1, 39'h0, 0, 0, 0);
    checkAll("drain2", 39'h77, 1, 1, 1, 0);
    applyStimulus(1, 39'h0, 0, 0, 0);
    checkAll("drain3", 39'h0, 0, 1, 0, 0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/uop_issue_queue.md
# uop_issue_queue

Buffers 39-bit micro-op words from the translator and drives the `Iword` bus into the RF stage, one uop per cycle. It is the producer end of the `Iword`/`pipe_stall` interface. It holds uops while the RF stage stalls and substitutes a NOP uop when empty. It discards all buffered uops on a PC redirect from the EXE stage.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `PTR_W`, 2: log2(DEPTH).
- `NOP_UOP`, 39'h0: word issued when empty or in reset; has EOI bit [27] = 0.

Ports (all synchronous to CLK):
- `CLK` in 1: clock. All state updates on the rising edge.
- `RST` in 1: reset. Synchronous, active-low.
- `uop_in` in 39: uop from translator. Bits [38:36] are the PC length field, [35:28] the Fmask, [27] the EOI, [26:21] the opcode.
- `uop_valid` in 1: `uop_in` is valid this cycle.
- `uop_ready` out 1: queue accepts `uop_in` this cycle.
- `Iword` out 39: uop presented to the RF stage.
- `issue_valid` out 1: `Iword` is a real queued uop (0 means NOP_UOP).
- `pipe_stall` in 1: RF stage cannot consume `Iword` this cycle.
- `PCupdate` in 1: EXE redirect; flush the queue.
- `occupancy` out PTR_W+1: number of valid entries.
- `eoi_pending` out PTR_W+1: number of valid entries with bit [27] = 1.

## Operation
- Storage is a circular buffer of DEPTH×39 bits, with head and tail pointers of PTR_W bits. Pointers wrap modulo DEPTH.
- Push happens when `uop_valid & uop_ready & ~PCupdate`. The uop is written at the tail, and tail and occupancy each increment by 1.
- Pop happens when `~pipe_stall & (occupancy != 0) & ~PCupdate`. Head increments and occupancy decrements by 1.
- When push and pop occur together, occupancy is unchanged. Both pointers advance.
- `uop_ready = RST & (occupancy != DEPTH)`. It depends only on registered state. There is no pass-through credit when full and popping in the same cycle.
- `Iword` and `issue_valid` are combinational from the head entry:
  - If `occupancy == 0` or `RST == 0`: `Iword = NOP_UOP` and `issue_valid = 0`.
  - Otherwise: `Iword` is the head entry and `issue_valid = 1`.
- There is no bypass. A uop pushed in cycle N is first visible on `Iword` in cycle N+1.
- `eoi_pending` tracks the EOI bits of valid entries. It is +1 on a push with `uop_in[27]` set, and −1 on a pop whose head has bit [27] set. When both happen in one cycle, the net change applies.
- Flush: `PCupdate = 1` in cycle N means, at the edge:
  - head = tail = 0, occupancy = 0, eoi_pending = 0.
  - No push and no pop that cycle, regardless of `uop_valid` and `pipe_stall`.
  - The `Iword` driven in cycle N is discarded by the RF stage through its own flush.
- Reset (`RST = 0` at an edge): head = tail = 0, occupancy = 0, eoi_pending = 0. Reset overrides flush, push and pop, and also applies mid-stream. Storage contents are don't-care.
- A stall with an empty queue has no effect; NOP_UOP is issued.
- A push into a full queue cannot occur because `uop_ready = 0`. If `uop_valid` is held, the uop is accepted in the first cycle where `uop_ready = 1`.

## Timing
- Reset values: `Iword = NOP_UOP`, `issue_valid = 0`, `uop_ready = 0` while RST is low and 1 from the first cycle after release, `occupancy = 0`, `eoi_pending = 0`.
- Push to issue latency is 1 cycle with an empty queue.
- Throughput is 1 uop per cycle in steady state with `pipe_stall = 0`.
- `pipe_stall` is sampled in the same cycle as `Iword`. A stalled uop stays on `Iword` unchanged until a cycle with `pipe_stall = 0`.
- After a flush in cycle N:
  - Cycle N+1 shows NOP_UOP with `uop_ready = 1`.
  - A uop pushed in N+1 issues in N+2.
- The combinational paths are `Iword`/`issue_valid` from registers only, and `uop_ready` from registers plus RST. There is no path from `uop_valid` or `pipe_stall` to any output.

## Test plan
- Reset, then push A=39'h1, B=39'h2, C=39'h8000002 (EOI) in consecutive cycles with `pipe_stall = 0` → `Iword` shows A, B, C in cycles 2, 3, 4. `eoi_pending` peaks at 1 and returns to 0 after C pops.
- With `pipe_stall = 1`, push 5 uops into DEPTH=4 → `uop_ready` drops after the 4th push and the 5th is held. Release the stall → `Iword` shows entries 1–4 in order, the 5th is accepted when ready rises, and occupancy never exceeds 4.
- Full queue, then push and pop in the same cycle → `uop_ready = 0` blocks the push and occupancy goes 4 → 3. The next cycle the push is accepted and occupancy stays 3 → 3. Pointer wrap keeps the order intact.
- Occupancy 3 with 2 EOIs, then `PCupdate = 1` with `uop_valid = 1` → next cycle `occupancy = 0`, `eoi_pending = 0`, `Iword = NOP_UOP`, and the flushed-cycle uop is not stored.
- Occupancy 2, then `RST = 0` for one cycle with push and pop requested → everything is cleared and `uop_ready = 0` during reset. After release, a push of 39'h3 issues one cycle later.
- Empty queue with `pipe_stall` toggling → `Iword = NOP_UOP`, `issue_valid = 0`, occupancy stays 0 and never underflows.
